// File: rtl/floatingpoint.sv
// rtl/floatingpoint.sv - single-precision float type, constants and operand classifier
package floatingpoint;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exponent;
      logic [22:0] mantissa;
   } float;

   typedef enum logic [2:0] {
      FP_ZERO,
      FP_DENORM,
      FP_NORMAL,
      FP_INF,
      FP_NAN
   } fp_class_t;

   localparam float       FP_CANON_NAN = 32'h7FC00000;
   localparam logic [7:0] FP_EXP_MAX   = 8'hFF;

   function automatic fp_class_t fp_classify(input float f);
      fp_class_t c;
      if (f.exponent == 8'h00) begin
         c = (f.mantissa == '0) ? FP_ZERO : FP_DENORM;
      end else if (f.exponent == FP_EXP_MAX) begin
         c = (f.mantissa == '0) ? FP_INF : FP_NAN;
      end else begin
         c = FP_NORMAL;
      end
      return c;
   endfunction

endpackage

// File: rtl/float_add_issue_if.sv
// rtl/float_add_issue_if.sv - operand, adder-side and result signals of the issue stage
interface float_add_issue_if;
   import floatingpoint::*;

   float InA;
   float InB;
   logic InValid;
   logic InReady;
   float AddOp1;
   float AddOp2;
   logic AddInputValid;
   float AddResult;
   logic AddResultValid;
   float Out;
   logic OutValid;
   logic OutReady;

   modport slave (
      input  InA, InB, InValid, AddResult, AddResultValid, OutReady,
      output InReady, AddOp1, AddOp2, AddInputValid, Out, OutValid
   );

   modport master (
      output InA, InB, InValid, AddResult, AddResultValid, OutReady,
      input  InReady, AddOp1, AddOp2, AddInputValid, Out, OutValid
   );
endinterface

// File: rtl/float_issue_fifo.sv
// rtl/float_issue_fifo.sv - power-of-two operand-pair FIFO with registered count
module float_issue_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   assign rdata = mem_q[rd_ptr_q];
   assign full  = (count_q == CW'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // Pointer, storage and occupancy update; pointers wrap naturally at DEPTH
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   // State register; payload storage needs no reset
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end
endmodule

// File: rtl/float_add_issue.sv
// rtl/float_add_issue.sv - operand issue / result collection around FloatAdder; optional FLOAT_ADD_TIMEOUT_EN
module float_add_issue
   import floatingpoint::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic             Clock,
   input  logic             Reset,
   float_add_issue_if.slave bus,
   output logic             Busy
);
   typedef enum logic [1:0] {IDLE, CHECK, LAUNCH, WAIT} state_t;
   localparam int CW = $clog2(DEPTH + 1);

   state_t        state_q, state_d;
   float          op_a_q, op_a_d, op_b_q, op_b_d, out_q, out_d;
   logic          out_valid_q, out_valid_d, rv_prev_q, rv_prev_d;
   logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [63:0]   fifo_rdata;
   logic [CW-1:0] fifo_count;
   fp_class_t     class_a, class_b;
   logic          zero_a, zero_b, bypass;
   float          bypass_res;
   logic          rv_rise, timed_out;

   assign fifo_push = bus.InValid && !fifo_full;
   assign rv_rise   = bus.AddResultValid && !rv_prev_q;

   float_issue_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
      .clk    (Clock),
      .resetn (Reset),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .wdata  ({bus.InA, bus.InB}),
      .rdata  (fifo_rdata),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

`ifdef FLOAT_ADD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_q, timer_d;

   assign timed_out = !rv_rise && (timer_q == TW'(TIMEOUT - 1));

   // WAIT watchdog: cleared while launching, counts every cycle spent waiting
   always_comb begin
      timer_d = timer_q;
      if (state_q == LAUNCH) begin
         timer_d = '0;
      end else if (state_q == WAIT) begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Watchdog register
   always_ff @(posedge Clock) begin
      if (!Reset) timer_q <= '0;
      else        timer_q <= timer_d;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timed_out      = 1'b0;
`endif

   // Special-case resolution; denormals behave as signed zeros
   always_comb begin
      class_a    = fp_classify(op_a_q);
      class_b    = fp_classify(op_b_q);
      zero_a     = (class_a == FP_ZERO) || (class_a == FP_DENORM);
      zero_b     = (class_b == FP_ZERO) || (class_b == FP_DENORM);
      bypass     = 1'b1;
      bypass_res = op_a_q;
      if ((class_a == FP_NAN) || (class_b == FP_NAN) ||
          ((class_a == FP_INF) && (class_b == FP_INF) && (op_a_q.sign != op_b_q.sign))) begin
         bypass_res = FP_CANON_NAN;
      end else if (class_a == FP_INF) begin
         bypass_res = op_a_q;
      end else if (class_b == FP_INF) begin
         bypass_res = op_b_q;
      end else if (zero_a && zero_b) begin
         bypass_res = {op_a_q.sign & op_b_q.sign, 31'b0};
      end else if (zero_a) begin
         bypass_res = op_b_q;
      end else if (zero_b) begin
         bypass_res = op_a_q;
      end else begin
         bypass = 1'b0;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (!fifo_empty && !out_valid_q) state_d = CHECK;
         CHECK:   state_d = bypass ? IDLE : LAUNCH;
         LAUNCH:  state_d = WAIT;
         WAIT:    if (rv_rise || timed_out) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath and output-register updates per state
   always_comb begin
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      rv_prev_d   = bus.AddResultValid;
      fifo_pop    = 1'b0;
      if (out_valid_q && bus.OutReady) out_valid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !out_valid_q) begin
               fifo_pop         = 1'b1;
               {op_a_d, op_b_d} = fifo_rdata;
            end
         end
         CHECK: begin
            if (bypass) begin
               out_d       = bypass_res;
               out_valid_d = 1'b1;
            end
         end
         WAIT: begin
            if (rv_rise) begin
               out_d       = bus.AddResult;
               out_valid_d = 1'b1;
            end else if (timed_out) begin
               out_d       = FP_CANON_NAN;
               out_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state_q     <= IDLE;
         op_a_q      <= '0;
         op_b_q      <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
         rv_prev_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         rv_prev_q   <= rv_prev_d;
      end
   end

   assign bus.InReady       = !fifo_full;
   assign bus.AddOp1        = op_a_q;
   assign bus.AddOp2        = op_b_q;
   assign bus.AddInputValid = (state_q == LAUNCH);
   assign bus.Out           = out_q;
   assign bus.OutValid      = out_valid_q;
   assign Busy              = (state_q != IDLE) || (fifo_count != '0);
endmodule

// File: tb/tb_float_add_issue.sv
// tb/tb_float_add_issue.sv - directed self-checking bench for float_add_issue with FloatAdder model
module tb_float_add_issue;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   int   n_tests = 0;
   int   n_fail  = 0;

   float_add_issue_if bus ();

   float_add_issue #(.DEPTH(4), .TIMEOUT(8)) dut (
      .Clock (clk),
      .Reset (rst_n),
      .bus   (bus),
      .Busy  (busy)
   );

   always #5 clk = ~clk;

   // adder model: mode 0 = one-cycle pulse, 1 = ResultValid stays high, 2 = never answers
   int          model_mode = 0;
   int          model_lat  = 2;
   logic [31:0] model_ret  = '0;
   int          late_req   = 0;
   int          late_ack   = 0;
   int          launches   = 0;
   int          cnt        = 0;

   initial begin
      logic rv_next;
      bus.AddResult      = '0;
      bus.AddResultValid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         rv_next = (model_mode == 1) ? bus.AddResultValid : 1'b0;
         if (late_req != late_ack) begin
            rv_next = 1'b1;
            late_ack++;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 1) rv_next = 1'b0;
            if (cnt == 0) begin
               rv_next       = 1'b1;
               bus.AddResult = model_ret;
            end
         end
         if (bus.AddInputValid) begin
            launches++;
            if (model_mode != 2) cnt = model_lat;
         end
         bus.AddResultValid = rv_next;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_pair(input logic [31:0] a, input logic [31:0] b, output bit acc);
      bus.InA     = a;
      bus.InB     = b;
      bus.InValid = 1'b1;
      acc         = bus.InReady;
      tick();
      bus.InValid = 1'b0;
   endtask

   // edges counted from the acceptance edge (which counts as 1)
   task automatic wait_out(output int edges);
      edges = 1;
      while (!bus.OutValid && edges < 100) begin
         tick();
         edges++;
      end
   endtask

   task automatic take_out();
      bus.OutReady = 1'b1;
      tick();
      bus.OutReady = 1'b0;
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ret;
      logic [31:0] exp;
      bit          launch;
   } vec_t;

   localparam int NV = 13;
   vec_t vec [NV];

   initial begin
      bit          acc;
      int          edges;
      int          base;
      int          got;
      logic [31:0] bp_exp [5];

      vec[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40400000, 1'b1};
      vec[1]  = '{32'h00000000, 32'h40A00000, 32'h0,        32'h40A00000, 1'b0};
      vec[2]  = '{32'h7F800000, 32'hFF800000, 32'h0,        32'h7FC00000, 1'b0};
      vec[3]  = '{32'h7FC00001, 32'h3F800000, 32'h0,        32'h7FC00000, 1'b0};
      vec[4]  = '{32'h80000000, 32'h00000000, 32'h0,        32'h00000000, 1'b0};
      vec[5]  = '{32'h80000000, 32'h80000000, 32'h0,        32'h80000000, 1'b0};
      vec[6]  = '{32'h00000001, 32'hC0000000, 32'h0,        32'hC0000000, 1'b0};
      vec[7]  = '{32'h7F800000, 32'h3F800000, 32'h0,        32'h7F800000, 1'b0};
      vec[8]  = '{32'h3F800000, 32'hFF800000, 32'h0,        32'hFF800000, 1'b0};
      vec[9]  = '{32'h7F800000, 32'h7F800000, 32'h0,        32'h7F800000, 1'b0};
      vec[10] = '{32'h40490FDB, 32'h80000000, 32'h0,        32'h40490FDB, 1'b0};
      vec[11] = '{32'h40400000, 32'hC0000000, 32'h3F800000, 32'h3F800000, 1'b1};
      vec[12] = '{32'h3F800000, 32'h7F800001, 32'h0,        32'h7FC00000, 1'b0};

      bus.InA      = '0;
      bus.InB      = '0;
      bus.InValid  = 1'b0;
      bus.OutReady = 1'b0;

      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rst Out", bus.Out, 32'h0);
      chk("rst OutValid", 32'(bus.OutValid), 32'h0);
      chk("rst AddInputValid", 32'(bus.AddInputValid), 32'h0);
      chk("rst AddOp1", bus.AddOp1, 32'h0);
      chk("rst AddOp2", bus.AddOp2, 32'h0);
      chk("rst Busy", 32'(busy), 32'h0);
      chk("rst InReady", 32'(bus.InReady), 32'h1);

      for (int i = 0; i < NV; i++) begin
         model_mode = 0;
         model_lat  = 2;
         model_ret  = vec[i].ret;
         base       = launches;
         push_pair(vec[i].a, vec[i].b, acc);
         wait_out(edges);
         chk($sformatf("v%0d Out", i), bus.Out, vec[i].exp);
         chk($sformatf("v%0d latency", i), 32'(edges), vec[i].launch ? 32'd6 : 32'd3);
         chk($sformatf("v%0d AddOp1", i), bus.AddOp1, vec[i].a);
         chk($sformatf("v%0d AddOp2", i), bus.AddOp2, vec[i].b);
         tick();
         tick();
         chk($sformatf("v%0d held OutValid", i), 32'(bus.OutValid), 32'h1);
         chk($sformatf("v%0d held Out", i), bus.Out, vec[i].exp);
         chk($sformatf("v%0d launches", i), 32'(launches - base), 32'(vec[i].launch));
         take_out();
         chk($sformatf("v%0d OutValid cleared", i), 32'(bus.OutValid), 32'h0);
      end

      // backpressure: six pairs offered back to back while the consumer stalls
      for (int i = 0; i < 6; i++) begin
         push_pair(32'h00000000, 32'h41000000 + 32'(i) * 32'h00100000, acc);
         chk($sformatf("bp accept %0d", i), 32'(acc), (i < 5) ? 32'h1 : 32'h0);
         if (i < 5) bp_exp[i] = 32'h41000000 + 32'(i) * 32'h00100000;
      end
      chk("bp InReady full", 32'(bus.InReady), 32'h0);
      chk("bp Busy", 32'(busy), 32'h1);
      got = 0;
      bus.OutReady = 1'b1;
      for (int c = 0; c < 100 && got < 5; c++) begin
         if (bus.OutValid) begin
            chk($sformatf("bp order %0d", got), bus.Out, bp_exp[got]);
            got++;
         end
         tick();
      end
      bus.OutReady = 1'b0;
      chk("bp result count", 32'(got), 32'd5);
      tick();
      chk("bp drained Busy", 32'(busy), 32'h0);

      // stale ResultValid: left high by op 1, must fall and rise again for op 2
      model_mode = 1;
      model_lat  = 2;
      model_ret  = 32'h40400000;
      push_pair(32'h3F800000, 32'h40000000, acc);
      wait_out(edges);
      chk("stale op1 Out", bus.Out, 32'h40400000);
      take_out();
      model_lat = 4;
      model_ret = 32'h40800000;
      push_pair(32'h40400000, 32'h3F800000, acc);
      wait_out(edges);
      chk("stale op2 Out", bus.Out, 32'h40800000);
      chk("stale op2 latency", 32'(edges), 32'd8);
      take_out();
      model_mode = 0;
      tick();

      // reset while waiting on the adder, followed by a late result pulse
      model_mode = 2;
      push_pair(32'h3F800000, 32'h3F800000, acc);
      repeat (5) tick();
      chk("rstwait Busy before", 32'(busy), 32'h1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      late_req++;
      repeat (4) tick();
      chk("rstwait OutValid", 32'(bus.OutValid), 32'h0);
      chk("rstwait Busy", 32'(busy), 32'h0);
      chk("rstwait InReady", 32'(bus.InReady), 32'h1);
      chk("rstwait Out", bus.Out, 32'h0);
      model_mode = 0;

`ifdef FLOAT_ADD_TIMEOUT_EN
      model_mode = 2;
      base       = launches;
      push_pair(32'h3F800000, 32'h40000000, acc);
      wait_out(edges);
      chk("timeout Out", bus.Out, 32'h7FC00000);
      chk("timeout latency", 32'(edges), 32'd12);
      chk("timeout launches", 32'(launches - base), 32'd1);
      take_out();
      late_req++;
      repeat (3) tick();
      chk("timeout late pulse ignored", 32'(bus.OutValid), 32'h0);
      model_mode = 0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/float_add_issue.md
Name: float_add_issue

Overview:
- Operand-issue and result-collection stage wrapped around FloatAdder.
- Buffers incoming operand pairs in a small FIFO and classifies each pair.
- Special-case pairs (zero, denormal, infinity, NaN) are resolved locally, bypassing the adder. Normal pairs are launched into FloatAdder with a one-cycle InputValid pulse, and the returned Result is captured.
- Presents results in order on a valid/ready output port.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, min 2.
- TIMEOUT, 64, max cycles in WAIT before abort; used only with FLOAT_ADD_TIMEOUT_EN.

Ports:
- Clock  in  1  single clock; all state updates on posedge.
- Reset  in  1  synchronous, active-low reset.
- InA  in  float(32)  operand 1.
- InB  in  float(32)  operand 2.
- InValid  in  1  operand pair offered.
- InReady  out  1  FIFO not full.
- AddOp1  out  float(32)  to FloatAdder Op1.
- AddOp2  out  float(32)  to FloatAdder Op2.
- AddInputValid  out  1  to FloatAdder InputValid.
- AddResult  in  float(32)  from FloatAdder Result.
- AddResultValid  in  1  from FloatAdder ResultValid.
- Out  out  float(32)  sum.
- OutValid  out  1  Out holds a result.
- OutReady  in  1  consumer accepts Out.
- Busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Reset (Reset==0 at posedge):
  - FIFO emptied (pointers and count 0). State = IDLE.
  - Outputs: Out=0, OutValid=0, AddInputValid=0, AddOp1=AddOp2=0, Busy=0.
  - InReady=1 from the first cycle after reset.
  - Reset mid-operation discards the in-flight pair. An AddResultValid seen outside WAIT is ignored.
- FIFO:
  - Push when InValid && InReady. InReady = (count != DEPTH), registered-count based; a pop in the same cycle does not raise InReady.
  - Pointers wrap modulo DEPTH. Push and pop in the same cycle keep count unchanged.
- FSM states: IDLE, CHECK, LAUNCH, WAIT.
  - IDLE: if FIFO non-empty && !OutValid, pop head into OpA/OpB regs, go to CHECK.
  - CHECK: classify each operand as ZERO (exp 0, mant 0), DENORM (exp 0, mant != 0; treated as signed zero), INF (exp 255, mant 0), NAN (exp 255, mant != 0), or NORMAL.
    - Either operand NAN, or INF+INF with opposite signs -> Out=FP_CANON_NAN.
    - Else any INF -> Out = that INF.
    - Else both zero -> Out = zero with sign = signA & signB.
    - Else one zero -> Out = other operand.
    - Any of these: OutValid<=1, go to IDLE.
    - Both NORMAL -> go to LAUNCH.
  - LAUNCH: AddInputValid=1 for exactly this cycle. Go to WAIT.
  - WAIT: capture AddResult into Out on the rising edge of AddResultValid (current 1, previous-cycle sample 0). Set OutValid<=1, go to IDLE. A level-high AddResultValid left over from the previous operation is never accepted.
- AddOp1/AddOp2 are driven from OpA/OpB and held stable from CHECK through the end of WAIT.
- Output: OutValid clears on OutValid && OutReady. Out is held until accepted.
- Latency, measured from acceptance with an empty pipeline:
  - Bypass: OutValid after 3 edges.
  - Adder path: 3 edges + adder latency + 1.
- Ordering: strictly FIFO order. At most one pair in flight.

Optional Feature:
- Macro: FLOAT_ADD_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT: Out=FP_CANON_NAN, OutValid<=1, go to IDLE.
  - A later AddResultValid rising edge is ignored because the FSM is no longer in WAIT.
- Undefined: no counter; WAIT is unbounded.

Decomposition:
- Package floatingpoint (extended):
  - Existing float typedef.
  - FP_CANON_NAN = 32'h7FC00000 and FP_EXP_MAX = 8'hFF.
  - fp_class_t enum {FP_ZERO, FP_DENORM, FP_NORMAL, FP_INF, FP_NAN}.
  - fp_classify function.
- The FSM state enum is local to the module.
- Sub-module: float_issue_fifo, parameterised by DEPTH and a 64-bit payload, providing push/pop/full/empty/count.

Test Plan:
- 0x3F800000 + 0x40000000 (1.0+2.0), adder model returns 0x40400000 -> exactly one AddInputValid pulse; Out=0x40400000; OutValid held until OutReady.
- 0x00000000 + 0x40A00000 -> AddInputValid never asserted; Out=0x40A00000 exactly 3 edges after acceptance.
- 0x7F800000 + 0xFF800000 -> Out=0x7FC00000. Also 0x7FC00001 + 0x3F800000 -> Out=0x7FC00000.
- OutReady=0, push 6 pairs, DEPTH=4:
  - The first pair completes and parks in Out; the next 4 fill the FIFO; InReady=0 on the 6th, which is not accepted.
  - Release OutReady -> the 5 results emerge in order.
- AddResultValid held high from the prior op while entering WAIT -> not captured until it falls and rises again.
- Reset asserted during WAIT, then a late AddResultValid pulse -> OutValid stays 0, Busy=0, FIFO empty.
- With FLOAT_ADD_TIMEOUT_EN: with TIMEOUT=8, adder never responds -> Out=0x7FC00000 after 8 cycles in WAIT.
